card_shoe: RTL

Sequential card source for the baccarat datapath: holds a shoe of `DECKS` standard 52-card decks and deals one card per request. Each card is encoded 1..13 (A=1 … 10=10, J=11, Q=12, K=13), the same encoding `scorehand` consumes. It deals without replacement, using a free-running LFSR to choose the starting rank, so no rank is dealt more than 4×`DECKS` times between shuffles. It sits upstream of the player/dealer hand registers, whose outputs feed `scorehand`.

---
 rtl/card_shoe.sv | 116 +++++++++++
 1 files changed

// File: rtl/card_shoe.sv
// card_shoe: multi-deck card source that deals one card (1..13) per request
// without replacement. A free-running LFSR picks the starting rank; the search
// then walks upward (wrapping 13 -> 1) until it finds a rank with cards left.
module card_shoe #(
    parameter int          DECKS = 1,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       deal_req,
    input  logic       shuffle,
    output logic [3:0] card,
    output logic       card_valid,
    output logic       busy,
    output logic [8:0] cards_left,
    output logic       shoe_empty
);

    // A zero seed would lock the LFSR, so substitute the default.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [5:0]  RANK_FULL = 6'(4 * DECKS);
    localparam logic [8:0]  SHOE_FULL = 9'(52 * DECKS);

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [3:0]  rank, rank_nxt;
    logic [5:0]  cnt [0:15];   // only ranks 1..13 are ever addressed
    logic        do_refill;
    logic        do_take;

    // Map a 4-bit random value onto rank 1..13 (value mod 13, plus 1).
    function automatic logic [3:0] start_rank(input logic [3:0] v);
        return (v >= 4'd13) ? (v - 4'd13 + 4'd1) : (v + 4'd1);
    endfunction

    // Advance to the next rank, wrapping King back to Ace.
    function automatic logic [3:0] next_rank(input logic [3:0] r);
        return (r == 4'd13) ? 4'd1 : (r + 4'd1);
    endfunction

    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign busy       = (state == SEARCH);
    assign shoe_empty = (cards_left == 9'd0);

    // Control registers: FSM state, rank under examination and the LFSR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rank  <= 4'd1;
            lfsr  <= LFSR_INIT;
        end else begin
            state <= state_nxt;
            rank  <= rank_nxt;
            lfsr  <= {lfsr[14:0], lfsr_fb};
        end
    end

    // Next-state logic: shuffle beats a simultaneous deal; an empty shoe drops requests.
    always_comb begin
        state_nxt = state;
        rank_nxt  = rank;
        do_refill = 1'b0;
        do_take   = 1'b0;
        case (state)
            IDLE: begin
                if (shuffle) begin
                    do_refill = 1'b1;
                end else if (deal_req && !shoe_empty) begin
                    rank_nxt  = start_rank(lfsr[3:0]);
                    state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (cnt[rank] != 6'd0) begin
                    do_take   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    rank_nxt = next_rank(rank);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shoe contents and dealt-card outputs; card_valid pulses on the take edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= (i >= 1 && i <= 13) ? RANK_FULL : 6'd0;
            end
            cards_left <= SHOE_FULL;
            card       <= 4'd0;
            card_valid <= 1'b0;
        end else begin
            card_valid <= do_take;
            if (do_refill) begin
                for (int i = 0; i < 16; i++) begin
                    cnt[i] <= (i >= 1 && i <= 13) ? RANK_FULL : 6'd0;
                end
                cards_left <= SHOE_FULL;
                card       <= 4'd0;
            end else if (do_take) begin
                cnt[rank]  <= cnt[rank] - 6'd1;
                cards_left <= cards_left - 9'd1;
                card       <= rank;
            end
        end
    end

endmodule
